// File: rtl/array_serializer_pkg.sv
// Shared definitions for the array serializer: security-level codes, modulus width, beat geometry.
// Latency: none (package only).
// Backpressure: not applicable.
package array_serializer_pkg;

  localparam logic [2:0] SEC_640  = 3'd1;
  localparam logic [2:0] SEC_976  = 3'd2;
  localparam logic [2:0] SEC_1344 = 3'd3;

  localparam int LANES_DEF = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Number of significant bits per lane for a given security level (q = 2^qbits).
  // Unknown codes fall back to the full 16-bit lane.
  function automatic logic [4:0] qbits(input logic [2:0] sec_lev);
    logic [4:0] r;
    case (sec_lev)
      SEC_640:            r = 5'd15;
      SEC_976, SEC_1344:  r = 5'd16;
      default:            r = 5'd16;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/array_serializer_lane_mask.sv
// Reduces one lane mod 2^qbits by clearing every bit at or above qbits.
// Latency: purely combinational.
// Backpressure: none; sits on the capture path.
module array_serializer_lane_mask #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] lane_in,
  input  logic [4:0]       qbits,
  output logic [WIDTH-1:0] lane_out
);

  // Keep bits below qbits, zero the rest.
  always_comb begin
    lane_out = '0;
    for (int k = 0; k < WIDTH; k++) begin
      lane_out[k] = (k < int'(qbits)) ? lane_in[k] : 1'b0;
    end
  end

endmodule

// File: rtl/array_serializer.sv
// Captures a T-lane array in one cycle (masked mod q) and streams it out as BEATS beats of LANES lanes.
// Latency: array accepted in cycle n -> beat 0 valid in cycle n+1; last beat in n+BEATS with i_ready high.
// Backpressure: beats hold stable while i_ready=0; o_ready rises on the last-beat handshake for zero-bubble reuse.
module array_serializer
  import array_serializer_pkg::*;
#(
  parameter int T     = 64,
  parameter int WIDTH = 16,
  parameter int LANES = LANES_DEF,
  localparam int BEATS = T / LANES,
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [T*WIDTH-1:0]     i_array,
  input  logic [2:0]             i_sec_lev,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [LANES*WIDTH-1:0] o_data,
  output logic [BW-1:0]          o_beat_idx,
  output logic                   o_last
);

  state_t state_q;
  state_t state_d;

  logic [BW-1:0]                         beat_q;
  logic [BEATS-1:0][LANES*WIDTH-1:0]     buf_q;
  logic [T*WIDTH-1:0]                    masked;
  logic [4:0]                            cap_qbits;
  logic                                  accept;
  logic                                  last_beat;

  // Security level only matters at the accept edge; the masked lanes are what get stored.
  assign cap_qbits = qbits(i_sec_lev);
  assign last_beat = (beat_q == BW'(BEATS - 1));
  assign accept    = i_valid && o_ready;

  genvar gi;
  generate
    for (gi = 0; gi < T; gi++) begin : g_lane
      array_serializer_lane_mask #(.WIDTH(WIDTH)) u_mask (
        .lane_in  (i_array[gi*WIDTH +: WIDTH]),
        .qbits    (cap_qbits),
        .lane_out (masked[gi*WIDTH +: WIDTH])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state: leave IDLE on accept; after the last beat either restart (new array) or idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_SEND;
      ST_SEND: if (i_ready && last_beat) state_d = accept ? ST_SEND : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state and beat position.
  always_comb begin
    o_valid = (state_q == ST_SEND);
    o_last  = (state_q == ST_SEND) && last_beat;
    o_ready = (state_q == ST_IDLE) || (o_last && i_ready);
  end

  // Beat counter: restarts on accept, advances per handshake, returns to 0 after the last beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      beat_q <= '0;
    end else if (accept) begin
      beat_q <= '0;
    end else if (state_q == ST_SEND && i_ready) begin
      beat_q <= last_beat ? '0 : beat_q + BW'(1);
    end
  end

  // Capture buffer: loaded only on accept, so upstream changes mid-transfer are ignored.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    buf_q <= '0;
    else if (accept) buf_q <= masked;
  end

  assign o_data     = buf_q[beat_q];
  assign o_beat_idx = beat_q;

endmodule

// File: tb/tb_array_serializer.sv
// Directed bench for array_serializer with a queue-based reference model and per-cycle comparison.
// Latency: n/a (testbench).
// Backpressure: drives i_ready patterns to exercise stalls.
module tb_array_serializer;

  localparam int T     = 64;
  localparam int WIDTH = 16;
  localparam int LANES = 4;
  localparam int BEATS = 16;

  logic                   i_clk = 1'b0;
  logic                   i_rst_n = 1'b0;
  logic                   i_valid = 1'b0;
  logic                   i_ready = 1'b0;
  logic [T*WIDTH-1:0]     i_array = '0;
  logic [2:0]             i_sec_lev = 3'd2;
  logic                   o_ready;
  logic                   o_valid;
  logic                   o_last;
  logic [LANES*WIDTH-1:0] o_data;
  logic [3:0]             o_beat_idx;

  array_serializer #(.T(T), .WIDTH(WIDTH), .LANES(LANES)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_array    (i_array),
    .i_sec_lev  (i_sec_lev),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_beat_idx (o_beat_idx),
    .o_last     (o_last)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct { logic [63:0] d; int idx; } beat_t;
  typedef struct { logic [63:0] d; int idx; logic last; int cyc; } xfer_t;

  beat_t mq[$];     // beats the model says are still owed downstream
  xfer_t xlog[$];   // beats actually transferred by the DUT
  int    cyc = 0;
  int    accepts = 0;

  function automatic logic [T*WIDTH-1:0] ramp(input int base);
    logic [T*WIDTH-1:0] r;
    for (int i = 0; i < T; i++) r[i*WIDTH +: WIDTH] = 16'(base + i);
    return r;
  endfunction

  function automatic logic [63:0] exp_beat(input logic [T*WIDTH-1:0] arr, input logic [2:0] sec, input int b);
    logic [63:0] r;
    logic [15:0] v;
    for (int j = 0; j < LANES; j++) begin
      v = arr[(b*LANES + j)*WIDTH +: WIDTH];
      if (sec == 3'd1) v = v % 17'h08000;
      r[j*WIDTH +: WIDTH] = v;
    end
    return r;
  endfunction

  // Reference model: an accepted array becomes BEATS queued beats; each handshake pops one.
  always @(posedge i_clk or negedge i_rst_n) begin
    bit rdy;
    bit acc;
    if (!i_rst_n) begin
      mq.delete();
    end else begin
      cyc++;
      rdy = (mq.size() == 0) || (mq.size() == 1 && i_ready);
      acc = rdy && i_valid;
      if (mq.size() != 0 && i_ready) void'(mq.pop_front());
      if (acc) begin
        accepts++;
        for (int b = 0; b < BEATS; b++) mq.push_back('{exp_beat(i_array, i_sec_lev, b), b});
      end
    end
  end

  // Compare DUT outputs against the model on the falling edge, and log handshakes.
  always @(negedge i_clk) begin
    bit ev;
    bit er;
    ev = (mq.size() != 0);
    er = (mq.size() == 0) || (mq.size() == 1 && i_ready);
    check("o_valid", 64'(o_valid), 64'(ev));
    check("o_ready", 64'(o_ready), 64'(er));
    if (ev) begin
      check("o_data", o_data, mq[0].d);
      check("o_beat_idx", 64'(o_beat_idx), 64'(mq[0].idx));
      check("o_last", 64'(o_last), 64'(mq[0].idx == BEATS - 1));
    end
    if (i_rst_n && o_valid && i_ready) xlog.push_back('{o_data, int'(o_beat_idx), o_last, cyc});
  end

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic send(input logic [T*WIDTH-1:0] arr, input logic [2:0] sec);
    int a0;
    a0 = accepts;
    i_array = arr;
    i_sec_lev = sec;
    i_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (accepts != a0) break;
    end
    i_valid = 1'b0;
    if (accepts == a0) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 300; n++) begin
      if (mq.size() == 0) return;
      tick();
    end
    check("idle_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    logic [T*WIDTH-1:0] ones;
    ones = '1;

    // Reset state
    #1;
    check("rst_o_ready", 64'(o_ready), 64'd1);
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_last", 64'(o_last), 64'd0);
    check("rst_o_data", o_data, 64'd0);
    check("rst_o_beat_idx", 64'(o_beat_idx), 64'd0);
    tick(); tick();
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    tick();

    // Basic ramp, sec level 2
    xlog.delete();
    send(ramp(0), 3'd2);
    wait_idle();
    tick();
    check("t1_count", 64'(xlog.size()), 64'd16);
    if (xlog.size() == 16) begin
      check("t1_beat0", xlog[0].d, 64'h0003_0002_0001_0000);
      check("t1_beat15", xlog[15].d, 64'h003F_003E_003D_003C);
      check("t1_last15", 64'(xlog[15].last), 64'd1);
      check("t1_last14", 64'(xlog[14].last), 64'd0);
      check("t1_idx15", 64'(xlog[15].idx), 64'd15);
    end
    check("t1_ready_after", 64'(o_ready), 64'd1);

    // Masking: sec 1 clears bit 15, sec 3 passes through
    xlog.delete();
    send(ones, 3'd1);
    wait_idle();
    tick();
    check("t2_count", 64'(xlog.size()), 64'd16);
    foreach (xlog[k]) check("t2_sec1_lane", xlog[k].d, 64'h7FFF_7FFF_7FFF_7FFF);
    xlog.delete();
    send(ones, 3'd3);
    wait_idle();
    tick();
    foreach (xlog[k]) check("t2_sec3_lane", xlog[k].d, 64'hFFFF_FFFF_FFFF_FFFF);

    // Backpressure: i_ready pattern 1,0,0,1
    xlog.delete();
    a0 = accepts;
    i_array = ramp(500);
    i_sec_lev = 3'd2;
    i_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      i_ready = (n % 4 == 0) || (n % 4 == 3);
      tick();
      if (accepts != a0) i_valid = 1'b0;
      if (accepts != a0 && mq.size() == 0) break;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    check("t3_count", 64'(xlog.size()), 64'd16);
    foreach (xlog[k]) check("t3_idx_order", 64'(xlog[k].idx), 64'(k));

    // Back-to-back arrays
    xlog.delete();
    a0 = accepts;
    i_array = ramp(0);
    i_sec_lev = 3'd2;
    i_valid = 1'b1;
    for (int n = 0; n < 50 && accepts == a0; n++) tick();
    i_array = ramp(100);
    for (int n = 0; n < 50 && accepts == a0 + 1; n++) tick();
    i_valid = 1'b0;
    wait_idle();
    tick();
    check("t4_count", 64'(xlog.size()), 64'd32);
    if (xlog.size() == 32) begin
      check("t4_no_bubble", 64'(xlog[16].cyc), 64'(xlog[15].cyc + 1));
      check("t4_b_beat0", xlog[16].d, 64'h0067_0066_0065_0064);
      check("t4_b_idx0", 64'(xlog[16].idx), 64'd0);
      check("t4_a_last", 64'(xlog[15].last), 64'd1);
    end

    // Upstream changes during SEND are ignored
    xlog.delete();
    send(ramp(200), 3'd2);
    tick();
    i_array = ones;
    i_sec_lev = 3'd1;
    wait_idle();
    tick();
    i_sec_lev = 3'd2;
    check("t5_count", 64'(xlog.size()), 64'd16);
    if (xlog.size() == 16) check("t5_beat3", xlog[3].d, 64'h00D7_00D6_00D5_00D4);

    // Reset mid-transfer at beat 5
    xlog.delete();
    send(ramp(0), 3'd2);
    for (int n = 0; n < 50; n++) begin
      if (mq.size() != 0 && mq[0].idx == 5) break;
      tick();
    end
    check("t6_reached_beat5", 64'(o_beat_idx), 64'd5);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("t6_async_valid", 64'(o_valid), 64'd0);
    check("t6_async_ready", 64'(o_ready), 64'd1);
    check("t6_async_idx", 64'(o_beat_idx), 64'd0);
    tick(); tick();
    i_rst_n = 1'b1;
    check("t6_ready_after", 64'(o_ready), 64'd1);
    xlog.delete();
    send(ramp(300), 3'd3);
    wait_idle();
    tick();
    check("t6_count", 64'(xlog.size()), 64'd16);
    if (xlog.size() == 16) begin
      check("t6_idx0", 64'(xlog[0].idx), 64'd0);
      check("t6_beat0", xlog[0].d, 64'h012F_012E_012D_012C);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
